// File: rtl/seq_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding, default sizing
// and a constant-safe clog2 for deriving address field widths.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int NUM_SEQ_DEF  = 4;
    localparam int SEQ_LEN_DEF  = 16;
    localparam int LED_W_DEF    = 8;
    localparam int TICK_DIV_DEF = 12_500_000;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
// Holding en low or pulsing clr restarts the period from zero.
module seq_tick_gen
    import seq_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk_50,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W   = clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || !en || (cnt_q == CNT_MAX)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/seq_player_ctrl.sv
// LED sequencer controller: selects a sequence from debounced buttons and steps a
// synchronous pattern ROM once per tick, registering the ROM word onto LEDS.
module seq_player_ctrl
    import seq_pkg::*;
#(
    parameter  int NUM_SEQ  = NUM_SEQ_DEF,
    parameter  int SEQ_LEN  = SEQ_LEN_DEF,
    parameter  int LED_W    = LED_W_DEF,
    parameter  int TICK_DIV = TICK_DIV_DEF,
    localparam int SEQ_W    = clog2(NUM_SEQ),
    localparam int STEP_W   = clog2(SEQ_LEN),
    localparam int ADDR_W   = SEQ_W + STEP_W
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              pb_seq_up,
    input  logic              pb_seq_dn,
    input  logic              run,
    input  logic [LED_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEQ_W-1:0]  seq_num,
    output logic [LED_W-1:0]  LEDS,
    output logic              seq_wrap
);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);

    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [SEQ_W-1:0]  seq_num_d;
    logic              up_p0;
    logic              dn_p0;
    logic              up_ev;
    logic              dn_ev;
    logic              seq_ev;
    logic              leds_load;
    logic              wrap_d;
    logic              tick;
    logic              tick_clr;
    logic              tick_en;

    // Button edge detect: one registered copy, event on the 0->1 transition
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            up_p0 <= 1'b0;
            dn_p0 <= 1'b0;
        end else begin
            up_p0 <= pb_seq_up;
            dn_p0 <= pb_seq_dn;
        end
    end

    assign up_ev  = pb_seq_up & ~up_p0;
    assign dn_ev  = pb_seq_dn & ~dn_p0;
    assign seq_ev = up_ev ^ dn_ev;

    seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_50 (clk_50),
        .reset  (reset),
        .clr    (tick_clr),
        .en     (tick_en),
        .tick   (tick)
    );

    // Next-state: play sequencing first, then a sequence change overrides everything
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        seq_num_d = seq_num;
        leds_load = 1'b0;
        wrap_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                leds_load = 1'b1;
                state_d   = run ? WAIT : IDLE;
            end
            WAIT: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (tick) begin
                    step_d  = step_q + STEP_W'(1);
                    wrap_d  = (step_q == STEP_LAST);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new sequence restarts at step 0; dropping leds_load keeps a fetch of the
        // old address from ever reaching LEDS
        if (seq_ev) begin
            seq_num_d = up_ev ? (seq_num + SEQ_W'(1)) : (seq_num - SEQ_W'(1));
            step_d    = '0;
            leds_load = 1'b0;
            wrap_d    = 1'b0;
            state_d   = run ? FETCH : IDLE;
        end

        tick_clr = seq_ev || (state_d == IDLE);
        tick_en  = (state_q != IDLE);
    end

    // Registered state and outputs; rom_addr is loaded from the next-state values so it
    // already shows {seq_num, step} during FETCH
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            seq_num  <= '0;
            rom_addr <= '0;
            LEDS     <= '0;
            seq_wrap <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            seq_num  <= seq_num_d;
            rom_addr <= {seq_num_d, step_d};
            seq_wrap <= wrap_d;
            if (leds_load) begin
                LEDS <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_seq_player_ctrl.sv
// Scoreboard bench for seq_player_ctrl with a 4x4 pattern ROM (ROM[a] = a + 8'h10)
// and a 4-cycle step period.
module tb_seq_player_ctrl;

    localparam int NUM_SEQ  = 4;
    localparam int SEQ_LEN  = 4;
    localparam int LED_W    = 8;
    localparam int TICK_DIV = 4;

    logic       clk_50;
    logic       reset;
    logic       pb_seq_up;
    logic       pb_seq_dn;
    logic       run;
    logic [7:0] rom_data;
    logic [3:0] rom_addr;
    logic [1:0] seq_num;
    logic [7:0] LEDS;
    logic       seq_wrap;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        int addr;
        int leds;
        int seq;
        int wrap;
    } exp_t;

    exp_t sb[$];

    seq_player_ctrl #(
        .NUM_SEQ  (NUM_SEQ),
        .SEQ_LEN  (SEQ_LEN),
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .pb_seq_up (pb_seq_up),
        .pb_seq_dn (pb_seq_dn),
        .run       (run),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .seq_num   (seq_num),
        .LEDS      (LEDS),
        .seq_wrap  (seq_wrap)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Synchronous pattern ROM: data one cycle after the address
    always @(posedge clk_50) rom_data <= 8'h10 + {4'h0, rom_addr};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input int addr, input int leds, input int seq, input int wrap);
        exp_t e;
        e.cyc  = cyc + k;
        e.addr = addr;
        e.leds = leds;
        e.seq  = seq;
        e.wrap = wrap;
        sb.push_back(e);
    endtask

    // Outputs frozen for the next n cycles
    task automatic push_hold(input int n, input int addr, input int leds, input int seq);
        for (int k = 1; k <= n; k++) begin
            push_exp(k, addr, leds, seq, 0);
        end
    endtask

    // Playback timeline starting with FETCH next cycle: address advances every
    // TICK_DIV cycles, LEDS follows two cycles behind each address
    task automatic push_play(input int seq, input int old_leds, input int n, input int st0);
        for (int j = 1; j <= n; j++) begin
            int stp;
            int lstp;
            int leds;
            int wrap;
            stp  = (st0 + (j - 1) / TICK_DIV) % SEQ_LEN;
            lstp = (j >= 3) ? (st0 + (j - 3) / TICK_DIV) % SEQ_LEN : 0;
            leds = (j < 3) ? old_leds : 8'h10 + seq * SEQ_LEN + lstp;
            wrap = (j > 1 && ((j - 1) % TICK_DIV) == 0 && stp == 0) ? 1 : 0;
            push_exp(j, seq * SEQ_LEN + stp, leds, seq, wrap);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    always @(negedge clk_50) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                check_val("sb_late", cyc, e.cyc);
            end else begin
                check_val("rom_addr", {28'b0, rom_addr}, e.addr);
                check_val("LEDS", {24'b0, LEDS}, e.leds);
                check_val("seq_num", {30'b0, seq_num}, e.seq);
                check_val("seq_wrap", {31'b0, seq_wrap}, e.wrap);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        push_hold(3, 0, 0, 0);
        wait_cyc(3);

        // Play from reset: 0,1,2,3,0 with a wrap pulse
        reset = 1'b1;
        run   = 1'b1;
        push_play(0, 8'h00, 20, 0);
        wait_cyc(20);

        // Down press coinciding with a tick: 0 -> 3, step restarts at 0
        pb_seq_dn = 1'b1;
        push_play(3, 8'h10, 10, 0);
        wait_cyc(5);
        pb_seq_dn = 1'b0;
        wait_cyc(5);

        // Up press during LATCH, held 50 cycles: 3 -> 0 once, stale word dropped
        pb_seq_up = 1'b1;
        push_play(0, 8'h1D, 63, 0);
        wait_cyc(50);
        pb_seq_up = 1'b0;
        wait_cyc(2);

        // Simultaneous up/dn while playing: timeline undisturbed
        pb_seq_up = 1'b1;
        pb_seq_dn = 1'b1;
        wait_cyc(10);
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        wait_cyc(1);

        // Pause in WAIT for 20 cycles, with a simultaneous press inside the pause
        run = 1'b0;
        push_hold(20, 3, 8'h13, 0);
        wait_cyc(5);
        pb_seq_up = 1'b1;
        pb_seq_dn = 1'b1;
        wait_cyc(5);
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        wait_cyc(10);

        // Resume re-fetches the same step, advance 4 cycles after FETCH
        run = 1'b1;
        push_play(0, 8'h13, 7, 3);
        wait_cyc(7);

        // Paused sequence change: LEDS keep the old pattern until play resumes
        run = 1'b0;
        push_hold(2, 0, 8'h10, 0);
        wait_cyc(2);
        pb_seq_up = 1'b1;
        push_hold(5, 4, 8'h10, 1);
        wait_cyc(3);
        pb_seq_up = 1'b0;
        wait_cyc(2);
        run = 1'b1;
        push_play(1, 8'h10, 5, 0);
        wait_cyc(6);

        // Asynchronous reset in the middle of LATCH
        reset = 1'b0;
        #1;
        check_val("rst_rom_addr", {28'b0, rom_addr}, 0);
        check_val("rst_LEDS", {24'b0, LEDS}, 0);
        check_val("rst_seq_num", {30'b0, seq_num}, 0);
        check_val("rst_seq_wrap", {31'b0, seq_wrap}, 0);
        for (int k = 0; k <= 2; k++) begin
            push_exp(k, 0, 0, 0, 0);
        end
        wait_cyc(2);

        // Play restarts at address 0
        reset = 1'b1;
        push_play(0, 8'h00, 8, 0);
        wait_cyc(8);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk_50);
        end
        check_val("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
